hash_channel_arbiter: RTL and testbench

HASH_CHANNEL_ARBITER -- requirements
Module: hash_channel_arbiter

---
 rtl/hash_channel_arbiter_pkg.sv | 28 ++
 rtl/hash_beat_skid_fifo.sv | 59 +++++
 rtl/hash_channel_arbiter.sv | 153 +++++++++++++++
 tb/tb_hash_channel_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/hash_channel_arbiter_pkg.sv
// Shared types for the hash channel arbiter: FSM states, beat record layout and
// the channel-id width helper.
package hash_channel_arbiter_pkg;

   localparam int HASH_ISSUE_WIDTH = 16;
   localparam int ADDR_WIDTH       = 32;
   localparam int NUM_CH_DEF       = 4;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_t;

   function automatic int ch_id_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int CH_W_DEF = ch_id_w(NUM_CH_DEF);

   // Field order matches the packed record moved through the skid FIFO.
   typedef struct packed {
      logic [CH_W_DEF-1:0]           ch;
      logic [ADDR_WIDTH-1:0]         head_addr;
      logic [HASH_ISSUE_WIDTH*8-1:0] data;
      logic                          delim;
   } beat_t;

endpackage

// File: rtl/hash_beat_skid_fifo.sv
// Two-entry FIFO between the arbiter and the hash engine; the full flag is
// registered so o_ready never reaches i_ready combinationally.
module hash_beat_skid_fifo #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop_ready,
   output logic         full,
   output logic         valid,
   output logic [W-1:0] dout
);

   logic [W-1:0] head_q, head_d, tail_q, tail_d;
   logic [1:0]   cnt_q, cnt_d;
   logic         pop;

   assign pop   = pop_ready && (cnt_q != 2'd0);
   assign full  = (cnt_q == 2'd2);
   assign valid = (cnt_q != 2'd0);
   assign dout  = head_q;

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      case ({push, pop})
         2'b10: begin
            if (cnt_q == 2'd0) head_d = din;
            else               tail_d = din;
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            head_d = tail_q;
            cnt_d  = cnt_q - 2'd1;
         end
         2'b11: begin
            // push is only allowed when not full, so occupancy is 1 here
            head_d = din;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= 2'd0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/hash_channel_arbiter.sv
// Round-robin stream arbiter feeding a hash engine, with per-channel head
// address counters and in-flight beat limiting.
//
// state     | meaning
// ST_IDLE   | no stream owns the output; pick next eligible channel
// ST_LOCKED | grant_q owns the output until its delim beat is accepted
module hash_channel_arbiter
   import hash_channel_arbiter_pkg::*;
#(
   parameter int NUM_CH  = 4,
   parameter int ISSUE_W = HASH_ISSUE_WIDTH,
   parameter int ADDR_W  = ADDR_WIDTH,
   parameter int CNT_W   = 4,
   localparam int CH_W   = ch_id_w(NUM_CH)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [CNT_W-1:0]            cfg_max_inflight,
   input  logic [NUM_CH-1:0]           i_valid,
   output logic [NUM_CH-1:0]           i_ready,
   input  logic [NUM_CH-1:0]           i_delim,
   input  logic [NUM_CH*ISSUE_W*8-1:0] i_data,
   output logic                        o_valid,
   input  logic                        o_ready,
   output logic [CH_W-1:0]             o_ch,
   output logic [ADDR_W-1:0]           o_head_addr,
   output logic [ISSUE_W*8-1:0]        o_data,
   output logic                        o_delim,
   input  logic                        ret_valid,
   input  logic [CH_W-1:0]             ret_ch,
   output logic                        err_underflow
);

   localparam int DW    = ISSUE_W * 8;
   localparam int REC_W = CH_W + ADDR_W + DW + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   arb_state_t         state_q, state_d;
   logic [CH_W-1:0]    grant_q, grant_d, last_q, last_d;
   logic [ADDR_W-1:0]  hcnt_q [NUM_CH];
   logic [ADDR_W-1:0]  hcnt_d [NUM_CH];
   logic [CNT_W-1:0]   infl_q [NUM_CH];
   logic [CNT_W-1:0]   infl_d [NUM_CH];
   logic [CNT_W-1:0]   cfg_q;
   logic               err_q, err_d;

   logic [NUM_CH-1:0]  below_lim, eligible, ready_vec;
   logic               fifo_full, push;
   logic [REC_W-1:0]   push_rec, head_rec;

   // Limit uses the registered config so a change lands on the next cycle.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         below_lim[c] = (infl_q[c] != CNT_MAX) &&
                        ((cfg_q == '0) || (infl_q[c] < cfg_q));
      end
      eligible = i_valid & below_lim;
   end

   always_comb begin
      ready_vec = '0;
      if (state_q == ST_LOCKED)
         ready_vec[grant_q] = !fifo_full && below_lim[grant_q];
      push     = ready_vec[grant_q] && i_valid[grant_q];
      push_rec = {grant_q, hcnt_q[grant_q], i_data[int'(grant_q)*DW +: DW], i_delim[grant_q]};
   end

   assign i_ready = ready_vec;

   always_comb begin
      logic found;
      found   = 1'b0;
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      hcnt_d  = hcnt_q;
      infl_d  = infl_q;
      err_d   = err_q;

      case (state_q)
         ST_IDLE: begin
            for (int i = 1; i <= NUM_CH; i++) begin
               int idx;
               idx = (int'(last_q) + i) % NUM_CH;
               if (!found && eligible[idx]) begin
                  found   = 1'b1;
                  grant_d = CH_W'(idx);
               end
            end
            if (found) state_d = ST_LOCKED;
         end
         ST_LOCKED: begin
            if (push && i_delim[grant_q]) begin
               state_d = ST_IDLE;
               last_d  = grant_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (push)
         hcnt_d[grant_q] = i_delim[grant_q] ? '0 : hcnt_q[grant_q] + ADDR_W'(ISSUE_W);

      for (int c = 0; c < NUM_CH; c++) begin
         logic inc, dec;
         inc = push && (grant_q == CH_W'(c));
         dec = ret_valid && (ret_ch == CH_W'(c));
         if (inc && !dec) begin
            if (infl_q[c] != CNT_MAX) infl_d[c] = infl_q[c] + 1'b1;
         end else if (dec && !inc) begin
            if (infl_q[c] == '0) err_d = 1'b1;
            else                 infl_d[c] = infl_q[c] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         last_q  <= CH_W'(NUM_CH - 1);
         cfg_q   <= '0;
         err_q   <= 1'b0;
         for (int c = 0; c < NUM_CH; c++) begin
            hcnt_q[c] <= '0;
            infl_q[c] <= '0;
         end
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cfg_q   <= cfg_max_inflight;
         err_q   <= err_d;
         hcnt_q  <= hcnt_d;
         infl_q  <= infl_d;
      end
   end

   hash_beat_skid_fifo #(.W(REC_W)) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .din       (push_rec),
      .pop_ready (o_ready),
      .full      (fifo_full),
      .valid     (o_valid),
      .dout      (head_rec)
   );

   assign {o_ch, o_head_addr, o_data, o_delim} = head_rec;
   assign err_underflow = err_q;

endmodule

// File: tb/tb_hash_channel_arbiter.sv
// Directed bench for hash_channel_arbiter: head addresses, round-robin order,
// in-flight limiting, back-pressure, underflow flag and mid-stream reset.
module tb_hash_channel_arbiter;

   localparam int NUM_CH = 4;
   localparam int DW     = 128;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [3:0]        cfg_max_inflight;
   logic [3:0]        i_valid, i_ready, i_delim;
   logic [4*DW-1:0]   i_data;
   logic              o_valid, o_ready;
   logic [1:0]        o_ch;
   logic [31:0]       o_head_addr;
   logic [DW-1:0]     o_data;
   logic              o_delim;
   logic              ret_valid;
   logic [1:0]        ret_ch;
   logic              err_underflow;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hash_channel_arbiter #(.NUM_CH(4), .ISSUE_W(16), .ADDR_W(32), .CNT_W(4)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .cfg_max_inflight (cfg_max_inflight),
      .i_valid          (i_valid),
      .i_ready          (i_ready),
      .i_delim          (i_delim),
      .i_data           (i_data),
      .o_valid          (o_valid),
      .o_ready          (o_ready),
      .o_ch             (o_ch),
      .o_head_addr      (o_head_addr),
      .o_data           (o_data),
      .o_delim          (o_delim),
      .ret_valid        (ret_valid),
      .ret_ch           (ret_ch),
      .err_underflow    (err_underflow)
   );

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      i_valid   = '0;
      i_delim   = '0;
      ret_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Present one beat, wait (bounded) for acceptance, then optionally check the
   // output head one cycle later.
   task automatic send(input string tag, input int ch, input logic [DW-1:0] data,
                       input logic delim, input logic [31:0] exp_addr,
                       input logic chk_out, input int exp_waits);
      int waits;
      i_valid[ch]          = 1'b1;
      i_delim[ch]          = delim;
      i_data[ch*DW +: DW]  = data;
      waits = 0;
      while (!i_ready[ch] && waits < 10) begin
         @(negedge clk);
         waits++;
      end
      chk({tag, "_wait"}, 160'(waits), 160'(exp_waits));
      if (i_ready[ch]) begin
         @(posedge clk);
         @(negedge clk);
         i_valid[ch] = 1'b0;
         i_delim[ch] = 1'b0;
         if (chk_out) begin
            chk({tag, "_hdr"}, {o_valid, o_ch, o_head_addr, o_delim},
                {1'b1, 2'(ch), exp_addr, delim});
            chk({tag, "_data"}, 160'(o_data), 160'(data));
         end
      end else begin
         i_valid[ch] = 1'b0;
         i_delim[ch] = 1'b0;
      end
   endtask

   initial begin
      int exp_order [5];
      int n;
      exp_order = '{0, 1, 2, 3, 0};
      rst_n            = 1'b0;
      cfg_max_inflight = '0;
      i_valid          = '0;
      i_delim          = '0;
      i_data           = '0;
      o_ready          = 1'b1;
      ret_valid        = 1'b0;
      ret_ch           = '0;

      // Reset state
      @(negedge clk);
      chk("rst_out", {o_valid, o_ch, o_head_addr, o_delim, i_ready, err_underflow}, '0);
      chk("rst_data", 160'(o_data), '0);
      rst_n = 1'b1;
      @(negedge clk);

      // ch0 three-beat stream, then a new stream restarts at 0
      send("s0b0", 0, 128'hA0, 1'b0, 32'd0,  1'b1, 1);
      send("s0b1", 0, 128'hA1, 1'b0, 32'd16, 1'b1, 0);
      send("s0b2", 0, 128'hA2, 1'b1, 32'd32, 1'b1, 0);
      @(negedge clk);
      chk("s0_drained", 160'(o_valid), 160'(1'b0));
      send("s0new", 0, 128'hA3, 1'b1, 32'd0, 1'b1, 1);

      // Round-robin among four single-beat streams
      do_reset();
      i_data  = {128'hD3, 128'hD2, 128'hD1, 128'hD0};
      i_delim = 4'b1111;
      i_valid = 4'b1111;
      n = 0;
      for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
         @(negedge clk);
         if (o_valid) begin
            chk($sformatf("rr_%0d", n), {o_ch, o_head_addr}, {2'(exp_order[n]), 32'd0});
            n++;
         end
      end
      chk("rr_count", 160'(n), 160'(5));
      i_valid = '0;
      i_delim = '0;

      // In-flight limit of 2 on ch1, released one beat per return
      do_reset();
      cfg_max_inflight = 4'd2;
      @(negedge clk);
      send("lim_b0", 1, 128'hB0, 1'b0, 32'd0,  1'b1, 1);
      send("lim_b1", 1, 128'hB1, 1'b0, 32'd16, 1'b1, 0);
      i_valid[1]          = 1'b1;
      i_data[1*DW +: DW]  = 128'hB2;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("lim_stall_%0d", k), 160'(i_ready[1]), 160'(1'b0));
         @(negedge clk);
      end
      ret_valid = 1'b1;
      ret_ch    = 2'd1;
      @(negedge clk);
      ret_valid = 1'b0;
      chk("lim_release", 160'(i_ready[1]), 160'(1'b1));
      @(posedge clk);
      @(negedge clk);
      chk("lim_b2_hdr", {o_valid, o_ch, o_head_addr}, {1'b1, 2'd1, 32'd32});
      chk("lim_b2_data", 160'(o_data), 160'(128'hB2));
      i_data[1*DW +: DW] = 128'hB3;
      chk("lim_restall", 160'(i_ready[1]), 160'(1'b0));
      @(negedge clk);
      chk("lim_restall2", {i_ready[1], err_underflow}, {1'b0, 1'b0});
      i_valid          = '0;
      cfg_max_inflight = '0;

      // Back-pressure: two beats buffer, third stalls, order preserved
      do_reset();
      o_ready = 1'b0;
      send("bp_a", 2, 128'hC0, 1'b0, 32'd0, 1'b1, 1);
      send("bp_b", 2, 128'hC1, 1'b0, 32'd16, 1'b0, 0);
      i_valid[2]         = 1'b1;
      i_delim[2]         = 1'b1;
      i_data[2*DW +: DW] = 128'hC2;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("bp_full_%0d", k), {i_ready[2], o_valid, o_head_addr, o_delim},
             {1'b0, 1'b1, 32'd0, 1'b0});
         chk($sformatf("bp_hold_%0d", k), 160'(o_data), 160'(128'hC0));
         @(negedge clk);
      end
      o_ready = 1'b1;
      #1;
      chk("bp_prepop", 160'(i_ready[2]), 160'(1'b0));
      @(negedge clk);
      chk("bp_second", {o_valid, o_head_addr, i_ready[2]}, {1'b1, 32'd16, 1'b1});
      chk("bp_second_data", 160'(o_data), 160'(128'hC1));
      @(negedge clk);
      i_valid = '0;
      i_delim = '0;
      chk("bp_third", {o_valid, o_head_addr, o_delim}, {1'b1, 32'd32, 1'b1});
      chk("bp_third_data", 160'(o_data), 160'(128'hC2));
      @(negedge clk);
      chk("bp_nodup", 160'(o_valid), 160'(1'b0));

      // Underflow on ch2 is sticky and leaves its count at zero
      do_reset();
      ret_valid = 1'b1;
      ret_ch    = 2'd2;
      @(negedge clk);
      ret_valid = 1'b0;
      chk("uf_set", 160'(err_underflow), 160'(1'b1));
      cfg_max_inflight = 4'd1;
      repeat (3) @(negedge clk);
      chk("uf_sticky", 160'(err_underflow), 160'(1'b1));
      send("uf_cnt0", 2, 128'hE0, 1'b1, 32'd0, 1'b1, 1);
      cfg_max_inflight = '0;

      // Mid-stream reset on ch3
      do_reset();
      o_ready = 1'b0;
      send("mr_a", 3, 128'hF0, 1'b0, 32'd0, 1'b1, 1);
      send("mr_b", 3, 128'hF1, 1'b0, 32'd16, 1'b0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mr_flush", {o_valid, o_ch, o_head_addr, o_delim, i_ready}, '0);
      chk("mr_flush_data", 160'(o_data), '0);
      @(negedge clk);
      rst_n   = 1'b1;
      o_ready = 1'b1;
      send("mr_restart", 3, 128'hF2, 1'b1, 32'd0, 1'b1, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
